pipeline_hazard_unit: RTL
=========================

# pipeline_hazard_unit

Parametrised hazard-detection and forwarding controller for the RV32IM pipeline. It sits beside the ID stage and tracks in-flight destination registers for DEPTH post-decode stages (default EX, MEM, WB). From that tracking it produces:
- the IF/ID stall,
- the ID/EX bubble,
- the branch flush,
- registered forwarding selects for the EX operand muxes.

It also keeps saturating stall and flush event counters. The current pipeline has no hazard handling; this block adds it without fixing the stage count or the load latency.

## Interface
Parameters:
- REG_AW, 5, register-address width
- DEPTH, 3, number of tracked post-decode stages (entry 1 = EX … entry DEPTH = WB)
- ALU_READY, 1, minimum entry index from which a non-load result may be forwarded
- LOAD_READY, 2, minimum entry index from which a load result may be forwarded (LOAD_READY ≥ ALU_READY, ≤ DEPTH)
- CNT_W, 32, event-counter width
- SW, $clog2(DEPTH+1), forward-select width (derived)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- BUSYWAIT  in  1  global memory stall (inst | data cache); freezes all state
- ID_VALID  in  1  ID holds a real instruction
- ID_RS1, ID_RS2  in  REG_AW  source registers of the ID instruction
- ID_RS1_USED, ID_RS2_USED  in  1  source operand actually read
- ID_RD  in  REG_AW  destination register of the ID instruction
- ID_REG_WRITE  in  1  ID instruction writes ID_RD
- ID_IS_LOAD  in  1  ID instruction is a load
- BRANCH_TAKEN  in  1  EX-stage redirect (PC_SEL)
- STALL  out  1  hold PC and IF/ID
- BUBBLE  out  1  load a NOP into ID/EX
- FLUSH  out  1  squash IF/ID and ID/EX contents
- FWD_SEL1, FWD_SEL2  out  SW  registered: 0 = register-file value, k = result of the producer that was entry k at decode
- STALL_CNT, FLUSH_CNT  out  CNT_W  saturating event counters

## Operation
- State: DEPTH entries {valid, rd, is_load}, plus FWD_SEL registers and the counters.
- Match at entry k: valid, rd == source, source used, rd ≠ 0. Register x0 never matches.
- Per source, the youngest (lowest-k) match decides:
  - if k < (is_load ? LOAD_READY : ALU_READY), it is a hazard;
  - otherwise the forward candidate is k;
  - with no match, the candidate is 0.
- STALL = BUBBLE = ID_VALID & hazard on either source & ~FLUSH.
- FLUSH = BRANCH_TAKEN. FLUSH has priority over STALL.
- Entry update, only when ~BUSYWAIT:
  - entry[k] ← entry[k-1] for k ≥ 2;
  - entry[1] ← ID info if ID_VALID & ~STALL & ~FLUSH & ID_REG_WRITE;
  - otherwise entry[1] is invalid.
  - The oldest entry falls off.
- FWD_SELx update, only when ~BUSYWAIT:
  - loads the candidate when ID advances (~STALL & ~FLUSH);
  - loads 0 on a stall or flush.
- Counters, only when ~BUSYWAIT:
  - STALL_CNT +1 per cycle with STALL;
  - FLUSH_CNT +1 per cycle with FLUSH;
  - both saturate at all-ones with no wrap.
- BUSYWAIT high: entries, FWD_SEL and counters all hold; STALL, BUBBLE and FLUSH are still driven combinationally.

## Timing
- Reset values: all entries invalid; FWD_SEL1 = FWD_SEL2 = 0; counters 0.
- STALL, BUBBLE and FLUSH are forced to 0 while RESET is high.
- RESET mid-stall clears the stall on the next cycle.
- STALL, BUBBLE and FLUSH are combinational, valid in the same cycle as their inputs.
- FWD_SEL is valid one edge after decode, i.e. while the consumer is in EX.
- A load-use hazard stalls for (LOAD_READY − 1) cycles, since the producer enters at entry 1 and advances one entry per non-busy cycle. Default: 1 cycle.
- A dependent ALU instruction never stalls with the defaults.
- Branch and stall together: FLUSH=1, STALL=0, the ID instruction is not recorded, and STALL_CNT does not increment.
- A producer past entry DEPTH is no longer tracked, and the consumer reads the register file (select 0).

## Test plan
1. add x5 then sub x6,x5,x1 back-to-back (defaults) → no stall; FWD_SEL1 = 1 one cycle after sub decodes.
2. lw x5 then add x7,x5,x5 → STALL = BUBBLE = 1 for exactly 1 cycle; then FWD_SEL1 = FWD_SEL2 = 2; STALL_CNT = 1. Repeat with LOAD_READY=3 → 2 stall cycles, FWD_SEL = 3.
3. Writes to x0 followed by a reader of x0 → never a stall; FWD_SEL = 0.
4. BRANCH_TAKEN together with a pending load-use → FLUSH = 1, STALL = 0; next cycle entry 1 is invalid; FLUSH_CNT = 1, STALL_CNT unchanged.
5. Load-use hazard, then BUSYWAIT high for 4 cycles → STALL stays 1 and entries and counters are frozen; stall resolves 1 non-busy cycle after BUSYWAIT drops.
6. CNT_W=4, 20 forced stall cycles → STALL_CNT saturates at 15. Asserting RESET mid-stall → all counters 0, STALL = 0, FWD_SEL = 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - hazard detection, forwarding select and event counters for the in-order pipeline
module pipeline_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 32,
  parameter int SW         = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BUSYWAIT,
  input  logic              ID_VALID,
  input  logic [REG_AW-1:0] ID_RS1,
  input  logic [REG_AW-1:0] ID_RS2,
  input  logic              ID_RS1_USED,
  input  logic              ID_RS2_USED,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic              ID_REG_WRITE,
  input  logic              ID_IS_LOAD,
  input  logic              BRANCH_TAKEN,
  output logic              STALL,
  output logic              BUBBLE,
  output logic              FLUSH,
  output logic [SW-1:0]     FWD_SEL1,
  output logic [SW-1:0]     FWD_SEL2,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  logic [DEPTH:1]    r_valid;
  logic [DEPTH:1]    r_load;
  logic [REG_AW-1:0] r_rd [1:DEPTH];
  logic [SW-1:0]     r_fwd1;
  logic [SW-1:0]     r_fwd2;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic [REG_AW-1:0] w_src [2];
  logic [1:0]        w_used;
  logic [1:0]        w_haz;
  logic [SW-1:0]     w_cand [2];
  logic              w_stall;
  logic              w_flush;
  logic              w_advance;

  assign w_src[0]  = ID_RS1;
  assign w_src[1]  = ID_RS2;
  assign w_used    = {ID_RS2_USED, ID_RS1_USED};

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    w_haz     = '0;
    w_cand[0] = '0;
    w_cand[1] = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (r_valid[k] && w_used[s] && (r_rd[k] == w_src[s]) && (r_rd[k] != '0)) begin
          w_haz[s]  = (k < (r_load[k] ? LOAD_READY : ALU_READY));
          w_cand[s] = w_haz[s] ? '0 : SW'(k);
        end
      end
    end
  end

  assign w_flush   = ~RESET & BRANCH_TAKEN;
  assign w_stall   = ~RESET & ID_VALID & (|w_haz) & ~w_flush;
  assign w_advance = ~w_stall & ~w_flush;

  assign STALL     = w_stall;
  assign BUBBLE    = w_stall;
  assign FLUSH     = w_flush;
  assign FWD_SEL1  = r_fwd1;
  assign FWD_SEL2  = r_fwd2;
  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid     <= '0;
      r_load      <= '0;
      for (int k = 1; k <= DEPTH; k++) r_rd[k] <= '0;
      r_fwd1      <= '0;
      r_fwd2      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!BUSYWAIT) begin
      for (int k = 2; k <= DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_load[k]  <= r_load[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      r_valid[1] <= ID_VALID & w_advance & ID_REG_WRITE;
      r_load[1]  <= ID_IS_LOAD;
      r_rd[1]    <= ID_RD;
      r_fwd1     <= w_advance ? w_cand[0] : '0;
      r_fwd2     <= w_advance ? w_cand[1] : '0;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

endmodule
